truth_table_lut_seq: RTL and testbench
======================================

Name: truth_table_lut_seq

Overview:
- Parametrised, reprogrammable successor to the fixed 3-input truth-table logic gates.
- Evaluates an N_IN-input Boolean function from a runtime-loadable truth table.
- Passes the input vector through a stability filter before evaluation, so transient input glitches never reach the output.
- Output is registered; the table is loaded bit-serially and committed atomically. Sits between input sensors/prior gates and downstream gate stages.

Parameters:
N_IN, 3, number of logic inputs (1..6)
TT_INIT, 8'hCC, reset truth table, width 2**N_IN; bit i = output for input vector value i
STABLE_CYCLES, 2, consecutive unchanged cycles required before a new input vector is accepted (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in  input  N_IN  input vector; in[N_IN-1] is MSB of table index
out  output  1  registered function output
out_changed  output  1  one-cycle pulse when out toggles
cfg_start  input  1  begin (or restart) a table load
cfg_valid  input  1  cfg_bit valid
cfg_bit  input  1  serial table bit, LSB (index 0) first
cfg_ready  output  1  high while in LOAD
cfg_done  output  1  one-cycle pulse on table commit
tt_active  output  2**N_IN  currently active truth table

Behaviour:
- Reset values: out=TT_INIT[0], out_changed=0, cfg_ready=0, cfg_done=0, tt_active=TT_INIT, accepted vector acc=0, in_q=0, stable count cnt=0, shadow=0, idx=0, state=IDLE.
- Input filter, every edge: in_q<=in; if in!=in_q then cnt<=0, else cnt<=min(cnt+1, STABLE_CYCLES).
- Accept: when cnt==STABLE_CYCLES and in_q!=acc, acc<=in_q on that edge.
- Latency: E0 = first edge sampling a new value. If in is held, acc updates at E0+STABLE_CYCLES+1; out updates one edge later, at E0+STABLE_CYCLES+2.
- Glitch rule: if in changes again inside the window, the count restarts. A pulse that returns to the accepted value produces no acc change and no out_changed.
- Output: every edge out<=tt_active[acc], using registered acc and tt_active. out_changed<=1 exactly when the new out differs from the current out.
- Config FSM, two states:
  - IDLE: cfg_ready=0; cfg_valid ignored. cfg_start -> LOAD, idx<=0, shadow<=0.
  - LOAD: cfg_ready=1. On cfg_valid, shadow[idx]<=cfg_bit and idx<=idx+1.
  - When the bit at idx=2**N_IN-1 is accepted: tt_active<=shadow including that bit, cfg_done<=1 on the same edge (visible the following cycle), state->IDLE.
- Commit edge Ec: tt_active and cfg_done become visible after Ec; out reflects the new table after Ec+1.
- Old table stays fully active during LOAD until commit.
- Simultaneous events:
  - cfg_start in LOAD: abort and restart (idx<=0, shadow<=0); a cfg_valid in the same cycle is discarded.
  - cfg_start with cfg_valid in IDLE: the bit is discarded.
  - Acceptance and commit on the same edge: both take effect; out at the next edge uses the new acc and the new table.
- Reset mid-load: returns to IDLE, tt_active=TT_INIT, partial shadow discarded, no cfg_done.
- Width rules: idx is clog2(2**N_IN)+1 bits wide, so it never wraps within a load. cnt saturates at STABLE_CYCLES.

Test Plan:
- Reset, N_IN=3, in=3'b000 -> out=0, tt_active=8'hCC, cfg_ready=0. Step in=3'b010 held -> acc=2 at E0+3, out=1 with out_changed pulse at E0+4 (STABLE_CYCLES=2).
- Glitch: from acc=0 (out=0), in=3'b010 for 2 cycles then back to 3'b000 -> acc, out unchanged, no out_changed.
- Load XOR3 8'h96: cfg_start, 8 bits LSB-first with cfg_valid gaps -> cfg_done single pulse, tt_active=8'h96. Sweep all 8 vectors, holding each 4+ cycles -> out matches parity each time.
- Commit while in=3'b111 held with old table 8'hCC (out=1), new table 8'h00 -> out=0 one edge after the cfg_done-setting edge, out_changed pulses once.
- Abort: after 5 bits, assert cfg_start with cfg_valid -> idx=0. A full 8-bit load of 8'hF0 then commits 8'hF0; the pre-abort bits have no effect.
- Reset after 3 bits of a load -> state IDLE, tt_active=8'hCC, no cfg_done. A subsequent cfg_valid in IDLE is ignored.

Source files
------------

// File: rtl/truth_table_lut_seq.sv
// Reprogrammable N_IN-input truth-table gate with a stability-filtered input
// vector, a registered output and a bit-serial, atomically committed table load.
module truth_table_lut_seq #(
  parameter int                     N_IN          = 3,
  parameter logic [(1<<N_IN)-1:0]   TT_INIT       = 8'hCC,
  parameter int                     STABLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in,
  output logic                   out,
  output logic                   out_changed,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic                   cfg_done,
  output logic [(1<<N_IN)-1:0]   tt_active
);

  localparam int TT_W  = 1 << N_IN;
  localparam int IDX_W = $clog2(TT_W) + 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   in_q, in_d;
  logic [N_IN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [TT_W-1:0]   shadow_q, shadow_d;
  logic [TT_W-1:0]   shadow_wr_s;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_q, out_d;
  logic              out_changed_q, out_changed_d;
  logic              cfg_done_q, cfg_done_d;

  // Input stability filter, accepted-vector update and output evaluation.
  always_comb begin
    in_d = in;
    if (in != in_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if ((cnt_q == CNT_MAX) && (in_q != acc_q)) begin
      acc_d = in_q;
    end else begin
      acc_d = acc_q;
    end
    // Evaluate with the registered vector and table so a commit and an
    // acceptance on the same edge both show up together one edge later.
    out_d         = tt_q[acc_q];
    out_changed_d = out_d ^ out_q;
  end

  // Configuration FSM: serial shadow fill, atomic commit into the active table.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    tt_d        = tt_q;
    cfg_done_d  = 1'b0;
    shadow_wr_s = shadow_q;
    shadow_wr_s[idx_q[IDX_W-2:0]] = cfg_bit;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = LOAD;
          idx_d    = {IDX_W{1'b0}};
          shadow_d = {TT_W{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          state_d  = LOAD;
          idx_d    = {IDX_W{1'b0}};
          shadow_d = {TT_W{1'b0}};
        end else if (cfg_valid) begin
          shadow_d = shadow_wr_s;
          idx_d    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          if (idx_q == IDX_LAST) begin
            tt_d       = shadow_wr_s;
            cfg_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d    = LOAD;
          end
        end else begin
          state_d  = LOAD;
        end
      end
      default: begin
        state_d  = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      in_q          <= {N_IN{1'b0}};
      acc_q         <= {N_IN{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      tt_q          <= TT_INIT;
      shadow_q      <= {TT_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      out_q         <= TT_INIT[0];
      out_changed_q <= 1'b0;
      cfg_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_q          <= in_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      tt_q          <= tt_d;
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      out_q         <= out_d;
      out_changed_q <= out_changed_d;
      cfg_done_q    <= cfg_done_d;
    end
  end

  assign out         = out_q;
  assign out_changed = out_changed_q;
  assign cfg_ready   = (state_q == LOAD);
  assign cfg_done    = cfg_done_q;
  assign tt_active   = tt_q;

endmodule

// File: tb/tb_truth_table_lut_seq.sv
// Directed self-checking bench for truth_table_lut_seq (N_IN=3, STABLE_CYCLES=2).
module tb_truth_table_lut_seq;

  logic       clk;
  logic       reset;
  logic [2:0] in;
  logic       out;
  logic       out_changed;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_ready;
  logic       cfg_done;
  logic [7:0] tt_active;

  int tests_run    = 0;
  int tests_failed = 0;
  int oc_count     = 0;
  int done_count   = 0;

  truth_table_lut_seq #(
    .N_IN          (3),
    .TT_INIT       (8'hCC),
    .STABLE_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .out         (out),
    .out_changed (out_changed),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .tt_active   (tt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge and tally pulses.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (out_changed) oc_count++;
    if (cfg_done) done_count++;
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic send_bits(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i % 2 == 1)) begin
        cfg_valid = 1'b0;
        cyc();
      end
      cfg_valid = 1'b1;
      cfg_bit   = v[i];
      cyc();
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic load_table(input logic [7:0] v, input bit gaps);
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    send_bits(v, gaps);
  endtask

  initial begin
    reset = 1'b1; in = 3'b000; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    @(negedge clk);
    cycn(2);
    check_eq("rst_out", {31'd0, out}, 32'd0);
    check_eq("rst_tt", {24'd0, tt_active}, 32'hCC);
    check_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
    check_eq("rst_done", {31'd0, cfg_done}, 32'd0);
    check_eq("rst_oc", {31'd0, out_changed}, 32'd0);
    reset = 1'b0;
    cycn(4);
    check_eq("idle_out", {31'd0, out}, 32'd0);

    // Step to 3'b010: acc at E0+3, out at E0+4 (CC[2]=1).
    oc_count = 0;
    in = 3'b010;
    cycn(4);
    check_eq("step_out_e3", {31'd0, out}, 32'd0);
    cyc();
    check_eq("step_out_e4", {31'd0, out}, 32'd1);
    check_eq("step_oc_e4", {31'd0, out_changed}, 32'd1);
    cyc();
    check_eq("step_oc_e5", {31'd0, out_changed}, 32'd0);
    check_eq("step_oc_cnt", oc_count, 32'd1);

    // Glitch: return to 0, then a 2-cycle pulse that must be filtered out.
    in = 3'b000;
    cycn(6);
    check_eq("glitch_pre", {31'd0, out}, 32'd0);
    oc_count = 0;
    in = 3'b010;
    cycn(2);
    in = 3'b000;
    cycn(8);
    check_eq("glitch_out", {31'd0, out}, 32'd0);
    check_eq("glitch_oc", oc_count, 32'd0);

    // Load XOR3 with valid gaps; old table remains active during the load.
    done_count = 0;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    check_eq("load_ready", {31'd0, cfg_ready}, 32'd1);
    check_eq("load_tt_old", {24'd0, tt_active}, 32'hCC);
    send_bits(8'h96, 1'b1);
    check_eq("xor_done", {31'd0, cfg_done}, 32'd1);
    check_eq("xor_tt", {24'd0, tt_active}, 32'h96);
    check_eq("xor_ready", {31'd0, cfg_ready}, 32'd0);
    cyc();
    check_eq("xor_done_cnt", done_count, 32'd1);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      in = vv;
      cycn(6);
      check_eq($sformatf("xor_sweep_%0d", v), {31'd0, out}, {31'd0, vv[0] ^ vv[1] ^ vv[2]});
    end

    // Commit while in=111 held: CC gives 1, 00 gives 0 one edge after commit.
    load_table(8'hCC, 1'b0);
    in = 3'b111;
    cycn(6);
    check_eq("commit_pre", {31'd0, out}, 32'd1);
    oc_count = 0;
    load_table(8'h00, 1'b0);
    check_eq("commit_tt", {24'd0, tt_active}, 32'h00);
    check_eq("commit_out_ec", {31'd0, out}, 32'd1);
    cyc();
    check_eq("commit_out_ec1", {31'd0, out}, 32'd0);
    check_eq("commit_oc", {31'd0, out_changed}, 32'd1);
    cycn(3);
    check_eq("commit_oc_cnt", oc_count, 32'd1);

    // Abort after 5 bits with cfg_valid alongside cfg_start, then load F0.
    done_count = 0;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      cyc();
    end
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    cyc();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    check_eq("abort_idx", {28'd0, dut.idx_q}, 32'd0);
    check_eq("abort_ready", {31'd0, cfg_ready}, 32'd1);
    send_bits(8'hF0, 1'b0);
    check_eq("abort_tt", {24'd0, tt_active}, 32'hF0);
    check_eq("abort_done_cnt", done_count, 32'd1);

    // Reset in the middle of a load.
    done_count = 0;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      cyc();
    end
    cfg_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_eq("mid_rst_ready", {31'd0, cfg_ready}, 32'd0);
    check_eq("mid_rst_tt", {24'd0, tt_active}, 32'hCC);
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    cycn(10);
    cfg_valid = 1'b0;
    check_eq("idle_valid_tt", {24'd0, tt_active}, 32'hCC);
    check_eq("idle_valid_ready", {31'd0, cfg_ready}, 32'd0);
    check_eq("mid_rst_done_cnt", done_count, 32'd0);

    // cfg_start together with cfg_valid in IDLE: that bit must not count.
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    cyc();
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      cyc();
    end
    cfg_valid = 1'b0;
    check_eq("start_valid_ready", {31'd0, cfg_ready}, 32'd1);
    check_eq("start_valid_nodone", done_count, 32'd0);
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    cyc();
    cfg_valid = 1'b0;
    check_eq("start_valid_tt", {24'd0, tt_active}, 32'h00);
    check_eq("start_valid_done", done_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
